ttt_auto_player: RTL
====================

Name: ttt_auto_player

Overview:
- Automated tic-tac-toe opponent that sits on the move bus of the game engine.
- Snoops the opponent's moves into a shadow 3x3 board, then computes its own reply with a multi-cycle line-scan strategy.
- Emits the reply as a one-cycle move strobe (x, y, player) that the integration mux presents to the engine's move inputs.
- It is the move-generating end of the engine's move interface.

Parameters:
- MY_PLAYER, 1: player code this block plays as (0 or 1); the opponent is the other code.
- FIRST_MOVE, 0: 1 means this block moves first after reset; 0 means it waits for an opponent move.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- obs_valid  input  1  opponent move strobe (same cycle as engine enable)
- obs_x  input  2  opponent move column
- obs_y  input  2  opponent move row
- obs_player  input  2  opponent move player code
- stop_game  input  1  engine game-over flag
- mv_valid  output  1  own move strobe, exactly one cycle per move
- mv_x  output  2  own move column
- mv_y  output  2  own move row
- mv_player  output  2  own player code, constant MY_PLAYER
- busy  output  1  high while in THINK_WIN, THINK_BLK, FALLBACK or ISSUE
- done  output  1  game over seen or no empty cell; sticky until reset
- moves_made  output  3  count of own moves issued (0..5)

Behaviour:
- Reset (reset==0 at posedge) has priority over everything:
  - all shadow cells = 3 (empty); last_player = 3
  - mv_valid=0, mv_x=0, mv_y=0, busy=0, done=0, moves_made=0
  - state = IDLE
- Reset asserted mid-THINK or mid-ISSUE aborts with no mv_valid.
- Board convention: cell[y][x]; cell codes 0/1 are players, 3 is empty.
- Observation, accepted only in IDLE. Legal iff all of:
  - obs_valid=1
  - obs_x<3 and obs_y<3
  - target cell empty
  - obs_player is 0 or 1, obs_player != MY_PLAYER, obs_player != last_player
- Illegal observations are ignored with no state change. obs_valid in any other state is ignored.
- Legal observation at edge E0:
  - write cell, set last_player
  - go to THINK_WIN with line index 0; the new cell is visible in the first THINK cycle
- Line order, index 0..7: rows y=0,1,2; columns x=0,1,2; main diagonal (0,0)(1,1)(2,2); anti-diagonal (2,0)(1,1)(0,2).
- THINK_WIN:
  - One line per cycle. Hit = two cells equal MY_PLAYER and the third empty; target = the empty cell.
  - Hit → ISSUE at the next edge.
  - After line 7 with no hit → THINK_BLK.
- THINK_BLK: same scan, testing for the opponent code; hit → ISSUE; after line 7 → FALLBACK.
- FALLBACK (1 cycle):
  - First empty of: centre (1,1); corners (0,0),(2,0),(0,2),(2,2); then the remaining cells in raster order.
  - No empty cell → DONE.
- ISSUE (1 cycle):
  - mv_valid=1 with mv_x/mv_y = target
  - shadow cell written with MY_PLAYER; last_player = MY_PLAYER; moves_made +1
  - next state IDLE
- Latency, counted as mv_valid high after edge En, where E0 samples obs:
  - WIN hit at line k: n=k+1
  - BLK hit at line k: n=k+9
  - fallback: n=18
- FIRST_MOVE=1: the first cycle after reset release enters THINK_WIN on the empty board, which resolves to centre at n=18.
- stop_game=1 sampled in any state except reset:
  - state goes to DONE; busy=0; done=1
  - mv_valid is never asserted, including when sampled in the ISSUE-entry cycle
  - DONE is left only by reset
- mv_x/mv_y hold their last value when mv_valid=0.

Optional Feature:
- Macro TTT_AUTO_BLOCK_EN.
- Defined: THINK_BLK is present as specified.
- Undefined: THINK_BLK is omitted. THINK_WIN after line 7 goes directly to FALLBACK, so the fallback latency is n=10 and opponent threats are not blocked.

Test Plan:
- MY_PLAYER=1, FIRST_MOVE=0. Opponent plays (x=1,y=1) → no hit in either scan; mv_valid at n=18 (n=10 with macro off) with (0,0), player 1; moves_made=1.
- Opponent (0,0) → own move (1,1) at n=18. Then opponent (1,0) → BLK hit on line 0, mv (2,0) at n=9. Then opponent (0,1) → WIN hit on line 7, mv (0,2) at n=8.
- Board: opponent (0,0); own (1,1); opponent (0,1).
  - Macro on → BLK hit on line 3, mv (0,2) at n=12.
  - Macro off → fallback mv (2,0) at n=10.
- Illegal observations are ignored: occupied cell, obs_x=3, obs_player=1, and a repeated opponent move with obs_player==last_player. Required: busy stays 0, no mv_valid, shadow board unchanged.
- stop_game raised at cycle 5 of THINK → done=1, busy=0, no mv_valid for 50 cycles. Then reset=0 for one cycle → all outputs return to reset values.
- FIRST_MOVE=1 → exactly one mv_valid, (1,1), at n=18 after reset release; no further mv_valid until a legal opponent move.

Source files
------------

// File: rtl/ttt_auto_player_if.sv
// Move bus between the game engine and the automatic player.
// The player drives mv_* (master); the engine side drives obs_* and stop_game (slave).
interface ttt_auto_player_if;
    logic       obs_valid;
    logic [1:0] obs_x;
    logic [1:0] obs_y;
    logic [1:0] obs_player;
    logic       stop_game;
    logic       mv_valid;
    logic [1:0] mv_x;
    logic [1:0] mv_y;
    logic [1:0] mv_player;

    modport master (
        input  obs_valid, obs_x, obs_y, obs_player, stop_game,
        output mv_valid, mv_x, mv_y, mv_player
    );

    modport slave (
        output obs_valid, obs_x, obs_y, obs_player, stop_game,
        input  mv_valid, mv_x, mv_y, mv_player
    );
endinterface

// File: rtl/ttt_auto_player.sv
// Automatic tic-tac-toe opponent: shadows the board, scans lines for win/block, falls back to a fixed cell order.
// Optional macro TTT_AUTO_BLOCK_EN adds the THINK_BLK scan for opponent threats.
module ttt_auto_player #(
    parameter int unsigned MY_PLAYER  = 1,
    parameter int unsigned FIRST_MOVE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    ttt_auto_player_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            moves_made
);

    localparam logic [1:0] MY_CODE  = 2'(MY_PLAYER);
    localparam logic [1:0] OPP_CODE = (MY_CODE == 2'd0) ? 2'd1 : 2'd0;
    localparam logic [1:0] EMPTY    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_THINK_WIN = 3'd1,
`ifdef TTT_AUTO_BLOCK_EN
        ST_THINK_BLK = 3'd2,
`endif
        ST_FALLBACK  = 3'd3,
        ST_ISSUE     = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t          state_r;
    logic [2:0]      line_r;
    logic [8:0][1:0] board_r;
    logic [1:0]      last_player_r;
    logic [3:0]      tgt_r;
    logic            fb_ready_r;
    logic            first_pending_r;
    logic            mv_valid_r;
    logic [1:0]      mv_x_r;
    logic [1:0]      mv_y_r;
    logic            busy_r;
    logic            done_r;
    logic [2:0]      moves_made_r;

    logic [3:0]  obs_idx_s;
    logic        obs_legal_s;
    logic [11:0] line_cells_s;
    logic [1:0]  scan_player_s;
    logic [1:0]  cell_a_s, cell_b_s, cell_c_s;
    logic        scan_hit_s;
    logic [3:0]  scan_tgt_s;
    logic        fb_found_s;
    logic [3:0]  fb_pick_s;
    logic        issue_go_s;
    logic [3:0]  issue_idx_s;

    // Flat cell indices (y*3+x) of the three cells of a line.
    function automatic logic [11:0] line_cells(input logic [2:0] line);
        case (line)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            3'd7:    line_cells = {4'd2, 4'd4, 4'd6};
            default: line_cells = {4'd0, 4'd1, 4'd2};
        endcase
    endfunction

    // Fallback preference: centre, corners, then the edge cells in raster order.
    function automatic logic [3:0] fb_order(input logic [3:0] k);
        case (k)
            4'd0:    fb_order = 4'd4;
            4'd1:    fb_order = 4'd0;
            4'd2:    fb_order = 4'd2;
            4'd3:    fb_order = 4'd6;
            4'd4:    fb_order = 4'd8;
            4'd5:    fb_order = 4'd1;
            4'd6:    fb_order = 4'd3;
            4'd7:    fb_order = 4'd5;
            4'd8:    fb_order = 4'd7;
            default: fb_order = 4'd4;
        endcase
    endfunction

    // Flat index to {y, x}.
    function automatic logic [3:0] idx_to_yx(input logic [3:0] idx);
        case (idx)
            4'd0:    idx_to_yx = {2'd0, 2'd0};
            4'd1:    idx_to_yx = {2'd0, 2'd1};
            4'd2:    idx_to_yx = {2'd0, 2'd2};
            4'd3:    idx_to_yx = {2'd1, 2'd0};
            4'd4:    idx_to_yx = {2'd1, 2'd1};
            4'd5:    idx_to_yx = {2'd1, 2'd2};
            4'd6:    idx_to_yx = {2'd2, 2'd0};
            4'd7:    idx_to_yx = {2'd2, 2'd1};
            4'd8:    idx_to_yx = {2'd2, 2'd2};
            default: idx_to_yx = {2'd0, 2'd0};
        endcase
    endfunction

    // Legality of the snooped opponent move.
    always_comb begin
        obs_idx_s   = ({2'b00, bus.obs_y} * 4'd3) + {2'b00, bus.obs_x};
        obs_legal_s = 1'b0;
        if (bus.obs_valid && (bus.obs_x != 2'd3) && (bus.obs_y != 2'd3)) begin
            obs_legal_s = (board_r[obs_idx_s] == EMPTY) &&
                          (bus.obs_player[1] == 1'b0) &&
                          (bus.obs_player != MY_CODE) &&
                          (bus.obs_player != last_player_r);
        end else begin
            obs_legal_s = 1'b0;
        end
    end

    // Line scan: two cells of the scanned player and one empty cell is a hit.
    always_comb begin
        line_cells_s  = line_cells(line_r);
        scan_player_s = (state_r == ST_THINK_WIN) ? MY_CODE : OPP_CODE;
        cell_a_s      = board_r[line_cells_s[11:8]];
        cell_b_s      = board_r[line_cells_s[7:4]];
        cell_c_s      = board_r[line_cells_s[3:0]];
        scan_hit_s    = 1'b0;
        scan_tgt_s    = line_cells_s[11:8];
        if (cell_a_s == EMPTY && cell_b_s == scan_player_s && cell_c_s == scan_player_s) begin
            scan_hit_s = 1'b1;
            scan_tgt_s = line_cells_s[11:8];
        end else if (cell_a_s == scan_player_s && cell_b_s == EMPTY && cell_c_s == scan_player_s) begin
            scan_hit_s = 1'b1;
            scan_tgt_s = line_cells_s[7:4];
        end else if (cell_a_s == scan_player_s && cell_b_s == scan_player_s && cell_c_s == EMPTY) begin
            scan_hit_s = 1'b1;
            scan_tgt_s = line_cells_s[3:0];
        end else begin
            scan_hit_s = 1'b0;
        end
    end

    // First empty cell in fallback preference order.
    always_comb begin
        fb_found_s = 1'b0;
        fb_pick_s  = 4'd4;
        for (int k = 0; k < 9; k++) begin
            if (!fb_found_s && board_r[fb_order(4'(k))] == EMPTY) begin
                fb_found_s = 1'b1;
                fb_pick_s  = fb_order(4'(k));
            end else begin
                fb_found_s = fb_found_s;
            end
        end
    end

    // Decide whether this cycle commits a move and which cell it takes.
    always_comb begin
        issue_go_s  = 1'b0;
        issue_idx_s = tgt_r;
        case (state_r)
            ST_THINK_WIN: begin
                issue_go_s  = scan_hit_s;
                issue_idx_s = scan_tgt_s;
            end
`ifdef TTT_AUTO_BLOCK_EN
            ST_THINK_BLK: begin
                issue_go_s  = scan_hit_s;
                issue_idx_s = scan_tgt_s;
            end
`endif
            ST_FALLBACK: begin
                issue_go_s  = fb_ready_r;
                issue_idx_s = tgt_r;
            end
            default: begin
                issue_go_s  = 1'b0;
                issue_idx_s = tgt_r;
            end
        endcase
    end

    // Player FSM, shadow board and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            line_r          <= 3'd0;
            board_r         <= {9{2'b11}};
            last_player_r   <= 2'd3;
            tgt_r           <= 4'd0;
            fb_ready_r      <= 1'b0;
            first_pending_r <= (FIRST_MOVE != 0);
            mv_valid_r      <= 1'b0;
            mv_x_r          <= 2'd0;
            mv_y_r          <= 2'd0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            moves_made_r    <= 3'd0;
        end else if (bus.stop_game) begin
            state_r    <= ST_DONE;
            mv_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
        end else begin
            mv_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (first_pending_r) begin
                        first_pending_r <= 1'b0;
                        state_r         <= ST_THINK_WIN;
                        line_r          <= 3'd0;
                        busy_r          <= 1'b1;
                    end else if (obs_legal_s) begin
                        board_r[obs_idx_s] <= bus.obs_player;
                        last_player_r      <= bus.obs_player;
                        state_r            <= ST_THINK_WIN;
                        line_r             <= 3'd0;
                        busy_r             <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_THINK_WIN: begin
                    if (scan_hit_s) begin
                        state_r <= ST_ISSUE;
                    end else if (line_r == 3'd7) begin
`ifdef TTT_AUTO_BLOCK_EN
                        state_r <= ST_THINK_BLK;
                        line_r  <= 3'd0;
`else
                        state_r    <= ST_FALLBACK;
                        fb_ready_r <= 1'b0;
`endif
                    end else begin
                        line_r <= line_r + 3'd1;
                    end
                end
`ifdef TTT_AUTO_BLOCK_EN
                ST_THINK_BLK: begin
                    if (scan_hit_s) begin
                        state_r <= ST_ISSUE;
                    end else if (line_r == 3'd7) begin
                        state_r    <= ST_FALLBACK;
                        fb_ready_r <= 1'b0;
                    end else begin
                        line_r <= line_r + 3'd1;
                    end
                end
`endif
                // The fallback pick is registered first, then committed on the next edge.
                ST_FALLBACK: begin
                    if (fb_ready_r) begin
                        state_r    <= ST_ISSUE;
                        fb_ready_r <= 1'b0;
                    end else if (fb_found_s) begin
                        tgt_r      <= fb_pick_s;
                        fb_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            if (issue_go_s) begin
                mv_valid_r            <= 1'b1;
                {mv_y_r, mv_x_r}      <= idx_to_yx(issue_idx_s);
                board_r[issue_idx_s]  <= MY_CODE;
                last_player_r         <= MY_CODE;
                moves_made_r          <= moves_made_r + 3'd1;
            end else begin
                mv_valid_r <= 1'b0;
            end
        end
    end

    assign bus.mv_valid  = mv_valid_r;
    assign bus.mv_x      = mv_x_r;
    assign bus.mv_y      = mv_y_r;
    assign bus.mv_player = MY_CODE;
    assign busy          = busy_r;
    assign done          = done_r;
    assign moves_made    = moves_made_r;

endmodule
